// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states, divisor helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input longint clk_freq, input longint baud);
        return int'((clk_freq + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, show-ahead read; push visible in level/empty one edge later.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_nxt;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign level_nxt = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with input FIFO; first start bit one edge after the pushing edge.
// Backpressure: ready drops when the FIFO is full; queued words go out back-to-back.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 1_152_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TEST_DIV   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        test_mode_i,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        tx_o
);

    localparam int BAUD_DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int MAX_DIV  = (BAUD_DIV > TEST_DIV) ? BAUD_DIV : TEST_DIV;
    localparam int CW       = $clog2(MAX_DIV + 1);
    localparam bit HAS_PAR  = (PARITY != PAR_NONE);

    if (BAUD_DIV < 2) begin : g_div_chk
        $error("uart_tx_cfg: baud divisor below 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_par_chk
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (TEST_DIV < 2) begin : g_tdiv_chk
        $error("uart_tx_cfg: TEST_DIV must be at least 2");
    end

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        div_q;
    logic [CW-1:0]        new_div;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] fifo_dat;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 par_q;
    logic                 par_bit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 bit_done;
    logic                 last_bit;
    logic                 last_stop;
    logic                 frame_start;
    logic                 to_idle;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (frame_start),
        .wr_data (data_i),
        .rd_data (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

    assign ready_o = !fifo_full;
    assign push    = valid_i && ready_o;

    assign bit_done  = (cnt == '0);
    assign last_bit  = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (state == STOP) && bit_done && (stop_cnt == 1'(STOP_BITS - 1));

    // A frame starts from IDLE or straight out of the final stop clock, so queued words have no gap.
    assign frame_start = !fifo_empty && ((state == IDLE) || last_stop);
    assign to_idle     = fifo_empty && ((state == IDLE) || last_stop);

    assign new_div = test_mode_i ? CW'(TEST_DIV) : CW'(BAUD_DIV);
    assign par_bit = (PARITY == PAR_ODD) ? ~^fifo_dat : ^fifo_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            cnt      <= '0;
            div_q    <= CW'(BAUD_DIV);
            sh       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            // When heading to IDLE the FIFO is empty, so only a same-edge push keeps busy up.
            busy_o <= !to_idle || push;

            if (state != IDLE) begin
                cnt <= bit_done ? div_q - CW'(1) : cnt - CW'(1);
            end

            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx_o    <= sh[0];
                        sh      <= sh >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (!last_bit) begin
                            tx_o    <= sh[0];
                            sh      <= sh >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (HAS_PAR) begin
                            state <= PAR;
                            tx_o  <= par_q;
                        end else begin
                            state    <= STOP;
                            tx_o     <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end
                end
                PAR: begin
                    if (bit_done) begin
                        state    <= STOP;
                        tx_o     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase

            // test_mode_i only takes effect here, at the start of a frame.
            if (frame_start) begin
                state <= START;
                tx_o  <= 1'b0;
                sh    <= fifo_dat;
                par_q <= par_bit;
                div_q <= new_div;
                cnt   <= new_div - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: 8N1, 7E2 and 7O2 instances, line decoded against a frame scoreboard.
module tb_uart_tx_cfg;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tm;
    logic [7:0] d0;
    logic       v0;
    logic [6:0] d12;
    logic       v1;
    logic       v2;
    logic       r0, r1, r2;
    logic       b0, b1, b2;
    logic       tx0, tx1, tx2;
    logic [2:0] l0, l1, l2;

    always #5 clk = ~clk;

    uart_tx_cfg dut0 (
        .clk(clk), .rst(rst), .data_i(d0), .valid_i(v0), .ready_o(r0),
        .test_mode_i(tm), .busy_o(b0), .level_o(l0), .tx_o(tx0)
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .data_i(d12), .valid_i(v1), .ready_o(r1),
        .test_mode_i(tm), .busy_o(b1), .level_o(l1), .tx_o(tx1)
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_i(d12), .valid_i(v2), .ready_o(r2),
        .test_mode_i(tm), .busy_o(b2), .level_o(l2), .tx_o(tx2)
    );

    int     total = 0;
    int     bad = 0;
    int     now = 0;
    frame_t exp_q[$];
    frame_t cur;
    int     mon_sel = 0;
    bit     mon_en = 0;
    bit     mon_started = 0;
    bit     in_frame = 0;
    int     fcyc = 0;
    int     match = 0;
    int     nframe = 0;
    int     first_start = 0;
    int     busy_cnt = 0;
    int     gap_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk_frame(input logic [8:0] d, input int dbits, input int par,
                                        input int stops, input int div);
        frame_t f;
        logic   p;
        int     n;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        p         = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[1+i] = d[i];
            p ^= d[i];
        end
        n = 1 + dbits;
        if (par != 0) begin
            f.bits[n] = (par == 1) ? ~p : p;
            n++;
        end
        f.nbits = n + stops;
        f.div   = div;
        return f;
    endfunction

    function automatic logic sel_line();
        return (mon_sel == 0) ? tx0 : (mon_sel == 1) ? tx1 : tx2;
    endfunction

    function automatic logic sel_busy();
        return (mon_sel == 0) ? b0 : (mon_sel == 1) ? b1 : b2;
    endfunction

    // Per-cycle line decoder: every clock of every bit must carry the expected level.
    task automatic sample();
        logic ln;
        logic bz;
        int   bi;
        ln = sel_line();
        bz = sel_busy();
        if (mon_en) begin
            if (mon_started && bz && !in_frame && ln === 1'b1) gap_cnt++;
            if (!in_frame && ln === 1'b0) begin
                chk("start_has_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    fcyc     = 0;
                    match    = 0;
                    nframe++;
                    if (!mon_started) begin
                        mon_started = 1'b1;
                        first_start = now;
                    end
                end
            end
            if (in_frame) begin
                bi = fcyc / cur.div;
                if (ln === cur.bits[bi]) match++;
                fcyc++;
                if (fcyc % cur.div == 0) begin
                    chk($sformatf("frame%0d_bit%0d_clocks", nframe, bi), match, cur.div);
                    match = 0;
                end
                if (fcyc == cur.nbits * cur.div) in_frame = 1'b0;
            end
            if (mon_started && bz) busy_cnt++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        now++;
        sample();
    endtask

    task automatic clear_meas();
        mon_started = 1'b0;
        busy_cnt    = 0;
        gap_cnt     = 0;
        first_start = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((sel_busy() || in_frame) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    initial begin
        logic [7:0] hello [5];
        logic [7:0] words [6];
        int         lows;
        int         highs;
        int         waited;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b1; tm = 1'b0; d0 = '0; v0 = 1'b0; d12 = '0; v1 = 1'b0; v2 = 1'b0;
        repeat (3) step();
        chk("rst_tx", tx0, 1);
        chk("rst_busy", b0, 0);
        chk("rst_ready", r0, 1);
        chk("rst_level", l0, 0);
        chk("rst_tx_7e2", tx1, 1);
        chk("rst_tx_7o2", tx2, 1);
        rst = 1'b0;
        step();

        // Single 0x41, normal rate
        clear_meas(); mon_sel = 0; mon_en = 1'b1;
        d0 = 8'h41; v0 = 1'b1;
        exp_q.push_back(mk_frame(9'h41, 8, 0, 1, 87));
        step();
        v0 = 1'b0;
        chk("a41_tx_high_on_push_edge", tx0, 1);
        chk("a41_busy_on_push_edge", b0, 1);
        chk("a41_level_after_push", l0, 1);
        step();
        chk("a41_tx_low_next_edge", tx0, 0);
        chk("a41_level_after_pop", l0, 0);
        wait_idle("a41_idle_timeout", 2000);
        chk("a41_busy_clocks", busy_cnt, 870);
        chk("a41_queue_drained", exp_q.size(), 0);
        chk("a41_tx_idle", tx0, 1);

        // "Hello" back-to-back
        clear_meas();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hello_ready_%0d", i), r0, 1);
            d0 = hello[i]; v0 = 1'b1;
            exp_q.push_back(mk_frame({1'b0, hello[i]}, 8, 0, 1, 87));
            step();
        end
        v0 = 1'b0;
        wait_idle("hello_idle_timeout", 6000);
        chk("hello_busy_clocks", busy_cnt, 4350);
        chk("hello_gap_clocks", gap_cnt, 0);
        chk("hello_queue_drained", exp_q.size(), 0);

        // Six words into a depth-4 FIFO: the sixth stalls until the first frame ends
        clear_meas();
        for (int i = 0; i < 6; i++) begin
            d0 = words[i]; v0 = 1'b1;
            if (i == 5) begin
                chk("six_ready_low_when_full", r0, 0);
                chk("six_level_full", l0, 4);
                waited = 0;
                while (r0 !== 1'b1 && waited < 2000) begin
                    step();
                    waited++;
                end
                chk("six_stall_ends_with_first_frame", now - first_start, 870);
            end else begin
                chk($sformatf("six_ready_%0d", i), r0, 1);
            end
            exp_q.push_back(mk_frame({1'b0, words[i]}, 8, 0, 1, 87));
            step();
        end
        v0 = 1'b0;
        wait_idle("six_idle_timeout", 7000);
        chk("six_frames_seen", nframe, 12);
        chk("six_busy_clocks", busy_cnt, 5220);
        chk("six_gap_clocks", gap_cnt, 0);
        chk("six_queue_drained", exp_q.size(), 0);

        // Test mode: 4 clk/bit, toggling mid-frame must not change bit widths
        clear_meas();
        tm = 1'b1; d0 = 8'hA5; v0 = 1'b1;
        exp_q.push_back(mk_frame(9'h0A5, 8, 0, 1, 4));
        step();
        v0 = 1'b0;
        repeat (10) step();
        tm = 1'b0;
        wait_idle("tmode_idle_timeout", 200);
        chk("tmode_busy_clocks", busy_cnt, 40);
        chk("tmode_queue_drained", exp_q.size(), 0);

        // 7E2 and 7O2 with 0x35 (four ones: even parity 0, odd parity 1)
        clear_meas(); mon_sel = 1;
        tm = 1'b1; d12 = 7'h35; v1 = 1'b1;
        exp_q.push_back(mk_frame(9'h035, 7, 2, 2, 4));
        step();
        v1 = 1'b0;
        wait_idle("even_idle_timeout", 200);
        chk("even_busy_clocks", busy_cnt, 44);
        chk("even_queue_drained", exp_q.size(), 0);

        clear_meas(); mon_sel = 2;
        v2 = 1'b1;
        exp_q.push_back(mk_frame(9'h035, 7, 1, 2, 4));
        step();
        v2 = 1'b0;
        wait_idle("odd_idle_timeout", 200);
        chk("odd_busy_clocks", busy_cnt, 44);
        chk("odd_queue_drained", exp_q.size(), 0);
        tm = 1'b0;

        // Reset in the third data bit of 0xFB with two words still queued
        mon_en = 1'b0; mon_sel = 0;
        d0 = 8'hFB; v0 = 1'b1; step();
        d0 = 8'h12; step();
        d0 = 8'h34; step();
        v0 = 1'b0;
        chk("rstmid_level_before", l0, 2);
        repeat (298) step();
        chk("rstmid_tx_data_bit2", tx0, 0);
        rst = 1'b1;
        step();
        chk("rstmid_tx", tx0, 1);
        chk("rstmid_busy", b0, 0);
        chk("rstmid_level", l0, 0);
        chk("rstmid_ready", r0, 1);
        rst = 1'b0;
        lows = 0; highs = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (tx0 !== 1'b1) lows++;
            if (b0 !== 1'b0) highs++;
        end
        chk("rstmid_no_start_after", lows, 0);
        chk("rstmid_no_busy_after", highs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
